svreal_mul_arb: RTL and testbench

- Shares one pipelined fixed-point svreal multiplier among N_REQ requesters.
- Each requester presents an (a, b) operand pair under valid/ready.
- A round-robin arbiter issues one pair per cycle into the multiplier pipeline.
- The product is realigned to the output format and returned on a single tagged response bus with backpressure.
- Sits between leaf arithmetic users (filter taps, gain stages) and one DSP-mapped multiplier, replacing per-user multiplier instances.

---
 rtl/svreal_mul_arb_pkg.sv | 23 ++
 rtl/svreal_mul_pipe.sv | 110 +++++++++++
 rtl/svreal_mul_arb.sv | 107 ++++++++++
 tb/tb_svreal_mul_arb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svreal_mul_arb_pkg.sv
// Shared helpers for the arbitrated svreal multiplier.
// Optional saturation build: define SVREAL_MUL_ARB_SAT_EN.
package svreal_mul_arb_pkg;

    function automatic int id_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int align_shift(
        input int a_exp,
        input int b_exp,
        input int c_exp
    );
        return (a_exp + b_exp) - c_exp;
    endfunction

    function automatic int next_ptr(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/svreal_mul_pipe.sv
// Multiply/align/reduce datapath with valid+id sideband and common enable.
// SVREAL_MUL_ARB_SAT_EN selects saturating reduction and a sat flag.
module svreal_mul_pipe
    import svreal_mul_arb_pkg::*;
#(
    parameter int A_WIDTH = 16,
    parameter int A_EXP   = -8,
    parameter int B_WIDTH = 17,
    parameter int B_EXP   = -9,
    parameter int C_WIDTH = 18,
    parameter int C_EXP   = -10,
    parameter int PIPE    = 2,
    parameter int IDW     = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               in_valid_i,
    input  logic [IDW-1:0]     in_id_i,
    input  logic [A_WIDTH-1:0] a_i,
    input  logic [B_WIDTH-1:0] b_i,
    output logic               out_valid_o,
    output logic [IDW-1:0]     out_id_o,
    output logic [C_WIDTH-1:0] out_c_o
`ifdef SVREAL_MUL_ARB_SAT_EN
    ,
    output logic               out_sat_o
`endif
);

    localparam int SH  = align_shift(A_EXP, B_EXP, C_EXP);
    localparam int ASH = (SH < 0) ? -SH : SH;
    localparam int PW  = A_WIDTH + B_WIDTH;
    localparam int IW  = PW + ASH + 1;

    logic               v0_q;
    logic [IDW-1:0]     id0_q;
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;

    logic [PW-1:0]        prod;
    logic signed [IW-1:0] sx;
    logic signed [IW-1:0] wide;
    logic [C_WIDTH:0]     res;

    // Stage data carries {sat, c}
    logic             v_q  [1:PIPE];
    logic [IDW-1:0]   id_q [1:PIPE];
    logic [C_WIDTH:0] d_q  [1:PIPE];

    always_comb begin
        prod = {{B_WIDTH{a_q[A_WIDTH-1]}}, a_q}
             * {{A_WIDTH{b_q[B_WIDTH-1]}}, b_q};
        sx   = {{(IW-PW){prod[PW-1]}}, prod};
        wide = (SH < 0) ? (sx >>> ASH) : (sx <<< ASH);
        res  = {1'b0, wide[C_WIDTH-1:0]};
`ifdef SVREAL_MUL_ARB_SAT_EN
        if (!(&wide[IW-1:C_WIDTH-1]) && |wide[IW-1:C_WIDTH-1]) begin
            res = wide[IW-1] ? {2'b11, {(C_WIDTH-1){1'b0}}}
                             : {2'b10, {(C_WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v0_q  <= 1'b0;
            id0_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            for (int k = 1; k <= PIPE; k++) begin
                v_q[k]  <= 1'b0;
                id_q[k] <= '0;
                d_q[k]  <= '0;
            end
        end else if (en_i) begin
            v0_q <= in_valid_i;
            if (in_valid_i) begin
                id0_q <= in_id_i;
                a_q   <= a_i;
                b_q   <= b_i;
            end
            v_q[1] <= v0_q;
            if (v0_q) begin
                id_q[1] <= id0_q;
                d_q[1]  <= res;
            end
            // Data only moves with a valid so bubbles leave outputs unchanged
            for (int k = 2; k <= PIPE; k++) begin
                v_q[k] <= v_q[k-1];
                if (v_q[k-1]) begin
                    id_q[k] <= id_q[k-1];
                    d_q[k]  <= d_q[k-1];
                end
            end
        end
    end

    assign out_valid_o = v_q[PIPE];
    assign out_id_o    = id_q[PIPE];
    assign out_c_o     = d_q[PIPE][C_WIDTH-1:0];

`ifdef SVREAL_MUL_ARB_SAT_EN
    assign out_sat_o = v_q[PIPE] & d_q[PIPE][C_WIDTH];
`else
    logic unused_hi;
    assign unused_hi = ^{wide[IW-1:C_WIDTH], d_q[PIPE][C_WIDTH]};
`endif

endmodule

// File: rtl/svreal_mul_arb.sv
// Round-robin shared svreal multiplier with tagged, backpressured response.
// Define SVREAL_MUL_ARB_SAT_EN for saturating output and rsp_sat.
module svreal_mul_arb
    import svreal_mul_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int A_WIDTH = 16,
    parameter int A_EXP   = -8,
    parameter int B_WIDTH = 17,
    parameter int B_EXP   = -9,
    parameter int C_WIDTH = 18,
    parameter int C_EXP   = -10,
    parameter int PIPE    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*A_WIDTH-1:0]   req_a,
    input  logic [N_REQ*B_WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [id_width(N_REQ)-1:0] rsp_id,
    output logic [C_WIDTH-1:0]         rsp_c
`ifdef SVREAL_MUL_ARB_SAT_EN
    ,
    output logic                       rsp_sat
`endif
);

    localparam int IDW = id_width(N_REQ);

    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     ptr_d;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     scan;
    logic               gnt_found;
    logic               stall;
    logic               hs;
    int                 sum;
    logic [A_WIDTH-1:0] a_arr [N_REQ];
    logic [B_WIDTH-1:0] b_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*A_WIDTH +: A_WIDTH];
        assign b_arr[i] = req_b[i*B_WIDTH +: B_WIDTH];
    end

    assign stall = rsp_valid & ~rsp_ready;

    // First valid requester at or after ptr, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        sum       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = int'(ptr_q) + i;
            if (sum >= N_REQ) sum = sum - N_REQ;
            scan = IDW'(sum);
            if (!gnt_found && req_valid[scan]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && !stall && gnt_found) req_ready[gnt_idx] = 1'b1;
    end

    assign hs    = |(req_valid & req_ready);
    assign ptr_d = hs ? IDW'(next_ptr(int'(gnt_idx), N_REQ)) : ptr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    svreal_mul_pipe #(
        .A_WIDTH(A_WIDTH),
        .A_EXP  (A_EXP),
        .B_WIDTH(B_WIDTH),
        .B_EXP  (B_EXP),
        .C_WIDTH(C_WIDTH),
        .C_EXP  (C_EXP),
        .PIPE   (PIPE),
        .IDW    (IDW)
    ) u_pipe (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (~stall),
        .in_valid_i (hs),
        .in_id_i    (gnt_idx),
        .a_i        (a_arr[gnt_idx]),
        .b_i        (b_arr[gnt_idx]),
        .out_valid_o(rsp_valid),
        .out_id_o   (rsp_id),
        .out_c_o    (rsp_c)
`ifdef SVREAL_MUL_ARB_SAT_EN
        ,
        .out_sat_o  (rsp_sat)
`endif
    );

endmodule

// File: tb/tb_svreal_mul_arb.sv
// Bench for svreal_mul_arb: directed scenarios plus random traffic
// against a transaction-level queue model.
module tb_svreal_mul_arb;

    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int BW   = 17;
    localparam int CW   = 18;
    localparam int PIPE = 2;
    localparam int SH   = (-8 + -9) - (-10);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_a;
    logic [N*BW-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [CW-1:0]     rsp_c;
`ifdef SVREAL_MUL_ARB_SAT_EN
    logic              rsp_sat;
`endif

    always #5 clk = ~clk;

    svreal_mul_arb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_c    (rsp_c)
`ifdef SVREAL_MUL_ARB_SAT_EN
        ,
        .rsp_sat  (rsp_sat)
`endif
    );

    int tests = 0;
    int fails = 0;

    int            q_id  [$];
    logic [CW-1:0] q_c   [$];
    logic          q_sat [$];
    int            q_age [$];
    int            mptr;
    int            last_id;
    logic [CW-1:0] last_c;
    int            gnt_log [$];

    logic          obs_valid;
    logic [CW-1:0] obs_c;
    int            obs_id;
    logic [N-1:0]  obs_ready;
    logic [N-1:0]  hs_mask;
    int            rr_cnt;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Real-valued product rescaled, then wrapped or clamped to CW bits
    task automatic calc(input logic [AW-1:0] a, input logic [BW-1:0] b,
                        output logic [CW-1:0] c, output logic s);
        longint p, v, lim;
        p = longint'($signed(a)) * longint'($signed(b));
        v = (SH < 0) ? (p >>> (-SH)) : (p <<< SH);
        c = v[CW-1:0];
        s = 1'b0;
`ifdef SVREAL_MUL_ARB_SAT_EN
        lim = (longint'(1) <<< (CW - 1));
        if (v > lim - 1) begin
            v = lim - 1;
            c = v[CW-1:0];
            s = 1'b1;
        end else if (v < -lim) begin
            v = -lim;
            c = v[CW-1:0];
            s = 1'b1;
        end
`else
        lim = 0;
        s = (lim != 0);
`endif
    endtask

    task automatic model_reset();
        q_id.delete();
        q_c.delete();
        q_sat.delete();
        q_age.delete();
        mptr    = 0;
        last_id = 0;
        last_c  = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [BW-1:0] b);
        req_valid[i]       = 1'b1;
        req_a[i*AW +: AW]  = a;
        req_b[i*BW +: BW]  = b;
    endtask

    task automatic rnd_req(input int i);
        logic [31:0] ra, rb;
        ra = $urandom;
        rb = $urandom;
        set_req(i, ra[AW-1:0], rb[BW-1:0]);
    endtask

    // One clock: check outputs just before the edge, then advance the model
    task automatic cyc();
        logic ev, st, s;
        logic [CW-1:0] c;
        logic [N-1:0] er;
        int g, j;
        @(negedge clk);
        #4;
        ev = (q_age.size() > 0) && (q_age[0] == PIPE);
        obs_valid = rsp_valid;
        obs_c     = rsp_c;
        obs_id    = int'(rsp_id);
        obs_ready = req_ready;
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
            chk("rsp_id", rsp_id, q_id[0]);
            chk("rsp_c", rsp_c, q_c[0]);
        end else begin
            chk("hold_id", rsp_id, last_id);
            chk("hold_c", rsp_c, last_c);
        end
`ifdef SVREAL_MUL_ARB_SAT_EN
        chk("rsp_sat", rsp_sat, ev ? q_sat[0] : 1'b0);
`endif
        st = ev && !rsp_ready;
        g = -1;
        for (int k = 0; k < N; k++) begin
            j = (mptr + k) % N;
            if (g < 0 && req_valid[j]) g = j;
        end
        er = '0;
        if (rst_n && !st && g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        hs_mask = er;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            hs_mask = '0;
        end else if (!st) begin
            if (ev) begin
                last_id = q_id.pop_front();
                last_c  = q_c.pop_front();
                s = q_sat.pop_front();
                g = (g < 0) ? g : g;
                j = q_age.pop_front();
            end
            foreach (q_age[k]) q_age[k] = q_age[k] + 1;
            if (er != '0) begin
                calc(req_a[g*AW +: AW], req_b[g*BW +: BW], c, s);
                q_id.push_back(g);
                q_c.push_back(c);
                q_sat.push_back(s);
                q_age.push_back(0);
                mptr = (g + 1) % N;
                gnt_log.push_back(g);
            end
        end
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        hs_mask   = '0;
        rr_cnt    = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state, with a request pending that must not be accepted
        req_valid[2] = 1'b1;
        cyc();
        chk("reset_ready", obs_ready, 4'b0000);
        chk("reset_valid", obs_valid, 1'b0);
        req_valid = '0;
        rst_n = 1'b1;

        // Single request: 1.5 * 2.0 from requester 1
        set_req(1, 16'd384, 17'd1024);
        cyc();
        req_valid &= ~hs_mask;
        chk("single_grant", obs_ready, 4'b0010);
        cyc();
        cyc();
        chk("single_early", obs_valid, 1'b0);
        cyc();
        chk("single_valid", obs_valid, 1'b1);
        chk("single_id", obs_id, 1);
        chk("single_c", obs_c, 18'd3072);

        // Sign: -0.5 * 0.25 from requester 0
        set_req(0, 16'hFF80, 17'd128);
        cyc();
        req_valid &= ~hs_mask;
        chk("sign_grant", obs_ready, 4'b0001);
        cyc();
        cyc();
        cyc();
        chk("sign_valid", obs_valid, 1'b1);
        chk("sign_id", obs_id, 0);
        chk("sign_c", obs_c, 18'h3FF80);

        // Round robin with all requesters continuously valid
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        gnt_log.delete();
        for (int i = 0; i < N; i++) rnd_req(i);
        for (int t = 0; t < 12; t++) begin
            cyc();
            if (t >= 3 && obs_valid) rr_cnt++;
            for (int i = 0; i < N; i++) if (hs_mask[i]) rnd_req(i);
        end
        for (int k = 0; k < 8; k++) chk("rr_order", gnt_log[k], k % N);
        chk("rr_throughput", rr_cnt, 9);

        // Backpressure for 3 cycles with a full pipeline
        rsp_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            cyc();
            chk("bp_ready", obs_ready, 4'b0000);
            chk("bp_valid", obs_valid, 1'b1);
            for (int i = 0; i < N; i++) if (hs_mask[i]) rnd_req(i);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (6) cyc();
        chk("bp_drained", q_age.size(), 0);

        // Overflow: 100.0 * 100.0
        set_req(2, 16'd25600, 17'd51200);
        cyc();
        req_valid &= ~hs_mask;
        cyc();
        cyc();
        cyc();
        chk("ovf_valid", obs_valid, 1'b1);
`ifdef SVREAL_MUL_ARB_SAT_EN
        chk("ovf_c", obs_c, 18'd131071);
`else
        chk("ovf_c", obs_c, 18'd16384);
`endif

        // Reset with two products in flight
        rnd_req(2);
        rnd_req(3);
        cyc();
        req_valid &= ~hs_mask;
        cyc();
        req_valid &= ~hs_mask;
        chk("mid_inflight", q_age.size(), 2);
        rst_n = 1'b0;
        rnd_req(0);
        rnd_req(3);
        cyc();
        chk("mid_rst_ready", obs_ready, 4'b0000);
        rst_n = 1'b1;
        cyc();
        req_valid &= ~hs_mask;
        chk("mid_no_stale", obs_valid, 1'b0);
        chk("mid_first_gnt", obs_ready, 4'b0001);
        repeat (6) begin
            cyc();
            req_valid &= ~hs_mask;
        end

        // Random traffic with random backpressure
        for (int t = 0; t < 400; t++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1) rnd_req(i);
            cyc();
            req_valid &= ~hs_mask;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) cyc();
        chk("final_drain", q_age.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
